operand_stack: RTL and testbench
================================

# operand_stack

Eight-entry, 8-bit operand stack that sits directly upstream of the ALU. It supplies the ALU's `stack0` and `stack1` operands from its top two entries and accepts the ALU results (`stack0_out`, `stack1_out`, `reg_out`) as write-back data. The controller drives one stack command per cycle. Illegal commands are blocked and flagged.

## Interface
- `DEPTH`, 8: number of entries, ≥2.
- `W`, 8: entry width in bits.
- `clk` in 1: the only clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd` in 3: stack command (encoding under Operation).
- `push_data` in W: value for PUSH.
- `wb0` in W: write-back value for the top entry (ALU `stack0_out`/`reg_out`).
- `wb1` in W: write-back value for the second entry (ALU `stack1_out`).
- `stack0` out W: top entry; 0 if `count`<1.
- `stack1` out W: second entry; 0 if `count`<2.
- `count` out $clog2(DEPTH+1): number of valid entries.
- `empty` out 1: `count`==0.
- `full` out 1: `count`==DEPTH.
- `err` out 1: sticky flag, set by any illegal command.

## Operation
- Storage `mem[0..DEPTH-1]`:
  - `mem[0]` is the bottom entry.
  - The top entry is `mem[count-1]`.
- Commands, with the required `count` and the effect:
  - 0 NOP: no requirement; no change.
  - 1 PUSH: needs `count`<DEPTH. Writes `mem[count]`←`push_data`, then `count`+1.
  - 2 POP: needs `count`≥1. `count`−1; the data word is not cleared.
  - 3 POP2: needs `count`≥2. `count`−2.
  - 4 WB0: needs `count`≥1. Writes top←`wb0`; `count` unchanged.
  - 5 WB01: needs `count`≥2. Writes top←`wb0` and second←`wb1`; `count` unchanged. This is the and-and-shift / abs write-back.
  - 6 BINOP: needs `count`≥2. Pops two, then pushes `wb0`. Result: `mem[count-2]`←`wb0`, `count`−1.
  - 7 DUP: needs `count`≥1 and `count`<DEPTH. Writes `mem[count]`←top, then `count`+1.
- Illegal command (its `count` requirement is not met):
  - Storage and `count` are unchanged.
  - `err`←1 on the same edge.
- `err` stays at 1 until `reset`; no command clears it.
- Only one command per cycle; there are no simultaneous push/pop ports.
- Read ports are pure combinational muxes of registered state. They have no dependence on `cmd`, `push_data`, `wb0` or `wb1`, so there is no combinational loop through the ALU.
- `count` arithmetic:
  - Unsigned.
  - It never wraps, because illegal commands are blocked.
  - Its range is 0..DEPTH.
- Data is opaque; no arithmetic is applied to entries.

## Timing
- On `reset` high at a rising edge:
  - `count`←0 and `err`←0.
  - All `mem` entries←0.
  - Outputs after that edge: `stack0`=0, `stack1`=0, `empty`=1, `full`=0, `err`=0.
- `reset` takes priority over any `cmd` in the same cycle. This includes reset asserted in the middle of a command sequence; the command is discarded.
- Write latency is 1 cycle: a command sampled at edge N is visible on `stack0`/`stack1`/`count` after edge N.
- Read latency is 0: outputs follow registered state within the same cycle.
- Back-to-back commands are allowed every cycle. The ALU result of cycle N, computed from `stack0`/`stack1` in cycle N, is written back at edge N.
- DUP and PUSH at `count`==DEPTH−1 set `full`=1 on the next cycle.
- POP at `count`==1 sets `empty`=1 and `stack0`=0 on the next cycle.

## Test plan
- Reset then PUSH 0x11, 0x22, 0x33 → `count`=3, `stack0`=0x33, `stack1`=0x22, `empty`=0, `err`=0.
- From that state, BINOP with `wb0`=0x55 → `count`=2, `stack0`=0x55, `stack1`=0x11. Then WB01 with `wb0`=0xA0, `wb1`=0x0B → `stack0`=0xA0, `stack1`=0x0B, `count`=2.
- PUSH 0x01..0x08 → `full`=1, `count`=8. A 9th PUSH 0xFF → `count`=8, `stack0`=0x08, `err`=1. `err` stays 1 through later NOPs.
- From reset, POP → `count`=0, `err`=1. After reset, PUSH 0x7F, then BINOP → `count`=1, `stack0`=0x7F, `err`=1.
- PUSH 0x80, DUP → `count`=2, `stack0`=`stack1`=0x80. POP2 → `empty`=1, `stack0`=`stack1`=0.
- PUSH 0x44 with `reset` asserted in the same cycle → `count`=0, `stack0`=0, `err`=0.

Source files
------------

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - eight-entry operand stack feeding the ALU, with guarded commands and sticky error
module operand_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    cmd,
  input  logic [W-1:0]  push_data,
  input  logic [W-1:0]  wb0,
  input  logic [W-1:0]  wb1,
  output logic [W-1:0]  stack0,
  output logic [W-1:0]  stack1,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          err
);

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_PUSH  = 3'd1;
  localparam logic [2:0] CMD_POP   = 3'd2;
  localparam logic [2:0] CMD_POP2  = 3'd3;
  localparam logic [2:0] CMD_WB0   = 3'd4;
  localparam logic [2:0] CMD_WB01  = 3'd5;
  localparam logic [2:0] CMD_BINOP = 3'd6;
  localparam logic [2:0] CMD_DUP   = 3'd7;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic          has_one, has_two, has_room, legal;
  logic [AW-1:0] cnt_idx, top_idx, sec_idx;

  assign has_one  = count_q >= CW'(1);
  assign has_two  = count_q >= CW'(2);
  assign has_room = count_q < CW'(DEPTH);
  // Indices are only dereferenced when the matching has_* guard holds.
  assign cnt_idx  = AW'(count_q);
  assign top_idx  = AW'(count_q - CW'(1));
  assign sec_idx  = AW'(count_q - CW'(2));

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    err_d   = err_q;
    legal   = 1'b1;
    case (cmd)
      CMD_PUSH:  legal = has_room;
      CMD_POP:   legal = has_one;
      CMD_POP2:  legal = has_two;
      CMD_WB0:   legal = has_one;
      CMD_WB01:  legal = has_two;
      CMD_BINOP: legal = has_two;
      CMD_DUP:   legal = has_one && has_room;
      default:   legal = 1'b1;
    endcase
    if (!legal) begin
      err_d = 1'b1;
    end else begin
      case (cmd)
        CMD_PUSH: begin
          mem_d[cnt_idx] = push_data;
          count_d        = count_q + CW'(1);
        end
        CMD_POP:  count_d = count_q - CW'(1);
        CMD_POP2: count_d = count_q - CW'(2);
        CMD_WB0:  mem_d[top_idx] = wb0;
        CMD_WB01: begin
          mem_d[top_idx] = wb0;
          mem_d[sec_idx] = wb1;
        end
        CMD_BINOP: begin
          mem_d[sec_idx] = wb0;
          count_d        = count_q - CW'(1);
        end
        CMD_DUP: begin
          mem_d[cnt_idx] = mem_q[top_idx];
          count_d        = count_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Reads depend on registered state only, so no loop forms through the ALU.
  assign stack0 = has_one ? mem_q[top_idx] : '0;
  assign stack1 = has_two ? mem_q[sec_idx] : '0;
  assign count  = count_q;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign err    = err_q;

endmodule

// File: tb/tb_operand_stack.sv
// tb/tb_operand_stack.sv - directed bench with a queue-based stack model and per-cycle compare
module tb_operand_stack;
  localparam int DEPTH = 8;
  localparam int W     = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    cmd = 3'd0;
  logic [W-1:0]  push_data = '0;
  logic [W-1:0]  wb0 = '0;
  logic [W-1:0]  wb1 = '0;
  logic [W-1:0]  stack0, stack1;
  logic [CW-1:0] count;
  logic          empty, full, err;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] mq[$];
  logic         m_err = 1'b0;
  logic         check_en = 1'b0;

  operand_stack #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .push_data(push_data),
    .wb0(wb0), .wb1(wb1), .stack0(stack0), .stack1(stack1),
    .count(count), .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stack semantics as a queue: back of the queue is the top entry.
  task automatic model_update(input logic rst, input logic [2:0] c, input logic [7:0] pd,
                              input logic [7:0] w0, input logic [7:0] w1);
    int sz;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
      check_en = 1'b1;
    end else begin
      case (c)
        3'd1: if (sz < DEPTH) mq.push_back(pd); else m_err = 1'b1;
        3'd2: if (sz >= 1) void'(mq.pop_back()); else m_err = 1'b1;
        3'd3: if (sz >= 2) begin void'(mq.pop_back()); void'(mq.pop_back()); end else m_err = 1'b1;
        3'd4: if (sz >= 1) mq[sz-1] = w0; else m_err = 1'b1;
        3'd5: if (sz >= 2) begin mq[sz-1] = w0; mq[sz-2] = w1; end else m_err = 1'b1;
        3'd6: if (sz >= 2) begin void'(mq.pop_back()); void'(mq.pop_back()); mq.push_back(w0); end
              else m_err = 1'b1;
        3'd7: if (sz >= 1 && sz < DEPTH) mq.push_back(mq[sz-1]); else m_err = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic [2:0] c, input logic [7:0] pd = 8'h00,
                      input logic [7:0] w0 = 8'h00, input logic [7:0] w1 = 8'h00,
                      input logic rst = 1'b0);
    @(negedge clk);
    cmd = c; push_data = pd; wb0 = w0; wb1 = w1; reset = rst;
    @(posedge clk);
    model_update(rst, c, pd, w0, w1);
    #1;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      int sz;
      sz = mq.size();
      chk("stack0", stack0, (sz >= 1) ? mq[sz-1] : 8'h00);
      chk("stack1", stack1, (sz >= 2) ? mq[sz-2] : 8'h00);
      chk("count", 8'(count), 8'(sz));
      chk("empty", 8'(empty), 8'(sz == 0));
      chk("full", 8'(full), 8'(sz == DEPTH));
      chk("err", 8'(err), 8'(m_err));
    end
  end

  initial begin
    step(3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("rst_count", 8'(count), 8'd0);
    chk("rst_stack0", stack0, 8'h00);
    chk("rst_empty", 8'(empty), 8'd1);
    chk("rst_full", 8'(full), 8'd0);
    chk("rst_err", 8'(err), 8'd0);

    step(3'd1, 8'h11); step(3'd1, 8'h22); step(3'd1, 8'h33);
    chk("p3_count", 8'(count), 8'd3);
    chk("p3_stack0", stack0, 8'h33);
    chk("p3_stack1", stack1, 8'h22);
    chk("p3_empty", 8'(empty), 8'd0);

    step(3'd6, 8'h00, 8'h55);
    chk("binop_count", 8'(count), 8'd2);
    chk("binop_stack0", stack0, 8'h55);
    chk("binop_stack1", stack1, 8'h11);

    step(3'd5, 8'h00, 8'hA0, 8'h0B);
    chk("wb01_stack0", stack0, 8'hA0);
    chk("wb01_stack1", stack1, 8'h0B);
    chk("wb01_count", 8'(count), 8'd2);
    chk("wb01_err", 8'(err), 8'd0);

    step(3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    for (int i = 1; i <= 8; i++) step(3'd1, 8'(i));
    chk("fill_full", 8'(full), 8'd1);
    chk("fill_count", 8'(count), 8'd8);
    step(3'd1, 8'hFF);
    chk("ovf_count", 8'(count), 8'd8);
    chk("ovf_stack0", stack0, 8'h08);
    chk("ovf_err", 8'(err), 8'd1);
    for (int i = 0; i < 3; i++) step(3'd0);
    chk("sticky_err", 8'(err), 8'd1);
    step(3'd3); step(3'd2);
    chk("drain_stack0", stack0, 8'h05);

    step(3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(3'd2);
    chk("pop_empty_count", 8'(count), 8'd0);
    chk("pop_empty_err", 8'(err), 8'd1);

    step(3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(3'd1, 8'h7F);
    step(3'd6, 8'h00, 8'hEE);
    chk("binop1_count", 8'(count), 8'd1);
    chk("binop1_stack0", stack0, 8'h7F);
    chk("binop1_err", 8'(err), 8'd1);

    step(3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(3'd1, 8'h80);
    step(3'd7);
    chk("dup_count", 8'(count), 8'd2);
    chk("dup_stack0", stack0, 8'h80);
    chk("dup_stack1", stack1, 8'h80);
    step(3'd3);
    chk("pop2_empty", 8'(empty), 8'd1);
    chk("pop2_stack0", stack0, 8'h00);
    chk("pop2_stack1", stack1, 8'h00);

    step(3'd1, 8'h05);
    step(3'd4, 8'h00, 8'h66);
    chk("wb0_stack0", stack0, 8'h66);
    step(3'd2);
    chk("pop1_empty", 8'(empty), 8'd1);
    chk("pop1_stack0", stack0, 8'h00);

    for (int i = 1; i <= 7; i++) step(3'd1, 8'(8'h10 + i));
    step(3'd7);
    chk("dupfull_full", 8'(full), 8'd1);
    chk("dupfull_stack0", stack0, 8'h17);
    chk("dupfull_stack1", stack1, 8'h17);
    step(3'd7);
    chk("dupovf_err", 8'(err), 8'd1);
    chk("dupovf_count", 8'(count), 8'd8);

    step(3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(3'd1, 8'h09);
    step(3'd1, 8'h44, 8'h00, 8'h00, 1'b1);
    chk("rstpush_count", 8'(count), 8'd0);
    chk("rstpush_stack0", stack0, 8'h00);
    chk("rstpush_err", 8'(err), 8'd0);
    step(3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
